// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data SRAM: CPU MEM stage vs. external
// load/debug port, with a starvation counter that periodically hands priority to ext.
module dmem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              arst_n,

   input  logic              cpu_req,
   input  logic              cpu_wen,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_stall,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,

   input  logic              ext_req,
   input  logic              ext_wen,
   input  logic [ADDR_W-1:0] ext_addr,
   input  logic [DATA_W-1:0] ext_wdata,
   output logic              ext_gnt,
   output logic              ext_rvalid,
   output logic [DATA_W-1:0] ext_rdata,

   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wen,
   output logic              mem_ren,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,

   output logic              dbg_pri_o,
   output logic [3:0]        dbg_starve_cnt_o
);

   typedef enum logic {PRI_CPU = 1'b0, PRI_EXT = 1'b1} pri_t;
   typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_CPU = 2'd1, OWN_EXT = 2'd2} owner_t;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   pri_t       pri_q, pri_d;
   logic [3:0] starve_cnt_q, starve_cnt_d;
   owner_t     rd_owner_q, rd_owner_d;

   logic cpu_win;
   logic ext_win;

   // Handshake: a requester raises req with wen/addr/wdata and holds all of them
   // stable until it sees gnt; the access is consumed on the cycle where req & gnt.
   // Grants are combinational and forced low while arst_n is asserted.
   always_comb begin
      cpu_win = 1'b0;
      ext_win = 1'b0;
      if (arst_n) begin
         if (cpu_req && (!ext_req || pri_q == PRI_CPU)) begin
            cpu_win = 1'b1;
         end else if (ext_req) begin
            ext_win = 1'b1;
         end
      end
   end

   assign cpu_gnt   = cpu_win;
   assign ext_gnt   = ext_win;
   assign cpu_stall = arst_n & cpu_req & ~cpu_win;

   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wen   = 1'b0;
      mem_ren   = 1'b0;
      if (cpu_win) begin
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
         mem_wen   = cpu_wen;
         mem_ren   = ~cpu_wen;
      end else if (ext_win) begin
         mem_addr  = ext_addr;
         mem_wdata = ext_wdata;
         mem_wen   = ext_wen;
         mem_ren   = ~ext_wen;
      end
   end

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (ext_win) begin
         starve_cnt_d = 4'd0;
      end else if (ext_req && arst_n) begin
         starve_cnt_d = (starve_cnt_q == 4'd15) ? 4'd15 : starve_cnt_q + 4'd1;
      end

      // Priority flips to ext on the edge the counter reaches the limit, and back
      // to the CPU only once ext has actually been served.
      pri_d = pri_q;
      if (pri_q == PRI_CPU) begin
         if (starve_cnt_d >= STARVE_LIM) pri_d = PRI_EXT;
      end else if (ext_win) begin
         pri_d = PRI_CPU;
      end

      rd_owner_d = OWN_NONE;
      if (cpu_win && !cpu_wen) begin
         rd_owner_d = OWN_CPU;
      end else if (ext_win && !ext_wen) begin
         rd_owner_d = OWN_EXT;
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         pri_q        <= PRI_CPU;
         starve_cnt_q <= 4'd0;
         rd_owner_q   <= OWN_NONE;
      end else begin
         pri_q        <= pri_d;
         starve_cnt_q <= starve_cnt_d;
         rd_owner_q   <= rd_owner_d;
      end
   end

   assign cpu_rvalid = (rd_owner_q == OWN_CPU);
   assign ext_rvalid = (rd_owner_q == OWN_EXT);
   assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
   assign ext_rdata  = ext_rvalid ? mem_rdata : '0;

   assign dbg_pri_o        = (pri_q == PRI_EXT);
   assign dbg_starve_cnt_o = starve_cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed plus randomized bench for dmem_arbiter against a behavioural reference
// of the arbitration, starvation and read-return rules, with a small SRAM model.
module tb_dmem_arbiter;

   localparam int N = 4;

   logic        clk = 1'b0;
   logic        arst_n;
   logic        cpu_req, cpu_wen, ext_req, ext_wen;
   logic [31:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
   logic        cpu_gnt, cpu_stall, cpu_rvalid, ext_gnt, ext_rvalid;
   logic [31:0] cpu_rdata, ext_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        mem_wen, mem_ren;
   logic        dbg_pri;
   logic [3:0]  dbg_starve;

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(N)) dut (
      .clk(clk), .arst_n(arst_n),
      .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .ext_req(ext_req), .ext_wen(ext_wen), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
      .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
      .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .dbg_pri_o(dbg_pri), .dbg_starve_cnt_o(dbg_starve)
   );

   // clock / reset
   always #5 clk = ~clk;

   // SRAM: writes on the edge, registered read data one cycle after mem_ren
   logic [31:0] sram [256];
   always @(posedge clk) begin
      if (mem_wen) sram[mem_addr[7:0]] <= mem_wdata;
      if (mem_ren) mem_rdata <= sram[mem_addr[7:0]];
   end

   // reference model and scoreboard
   int          checks = 0;
   int          failures = 0;
   int          m_starve;
   bit          m_ext_pri;
   bit          m_wcpu, m_wext;
   logic [31:0] ref_mem [256];
   logic [31:0] exp_q[$];
   bit          own_q[$];
   string       gseq, sseq;
   int          peak;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chks(input string tag, input string obs, input string exp);
      checks++;
      assert (obs == exp) else begin
         failures++;
         $error("FAIL %s observed=%s expected=%s", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_starve  = 0;
      m_ext_pri = 1'b0;
      exp_q.delete();
      own_q.delete();
   endtask

   // driver: one cycle from a negedge to the next negedge, checking before the posedge
   task automatic cycle(input logic creq, input logic cwen, input logic [31:0] caddr,
                        input logic [31:0] cwd, input logic ereq, input logic ewen,
                        input logic [31:0] eaddr, input logic [31:0] ewd);
      logic        e_wen, e_ren, o;
      logic [31:0] e_addr, e_wd, d;
      cpu_req = creq; cpu_wen = cwen; cpu_addr = caddr; cpu_wdata = cwd;
      ext_req = ereq; ext_wen = ewen; ext_addr = eaddr; ext_wdata = ewd;
      #1;
      m_wcpu = creq && (!ereq || !m_ext_pri);
      m_wext = ereq && !m_wcpu;
      e_wen  = m_wcpu ? cwen  : (m_wext ? ewen  : 1'b0);
      e_addr = m_wcpu ? caddr : (m_wext ? eaddr : 32'h0);
      e_wd   = m_wcpu ? cwd   : (m_wext ? ewd   : 32'h0);
      e_ren  = (m_wcpu || m_wext) && !e_wen;
      chk1("cpu_gnt", cpu_gnt, m_wcpu);
      chk1("ext_gnt", ext_gnt, m_wext);
      chk1("cpu_stall", cpu_stall, creq && !m_wcpu);
      chk1("mem_wen", mem_wen, e_wen);
      chk1("mem_ren", mem_ren, e_ren);
      chkw("mem_addr", mem_addr, e_addr);
      chkw("mem_wdata", mem_wdata, e_wd);
      chk1("pri", dbg_pri, m_ext_pri);
      chkw("starve_cnt", 32'(dbg_starve), 32'(m_starve));
      if (own_q.size() > 0) begin
         o = own_q.pop_front();
         d = exp_q.pop_front();
         chk1("cpu_rvalid", cpu_rvalid, !o);
         chk1("ext_rvalid", ext_rvalid, o);
         chkw("cpu_rdata", cpu_rdata, o ? 32'h0 : d);
         chkw("ext_rdata", ext_rdata, o ? d : 32'h0);
      end else begin
         chk1("cpu_rvalid", cpu_rvalid, 1'b0);
         chk1("ext_rvalid", ext_rvalid, 1'b0);
         chkw("cpu_rdata", cpu_rdata, 32'h0);
         chkw("ext_rdata", ext_rdata, 32'h0);
      end
      chk1("rvalid_excl", cpu_rvalid & ext_rvalid, 1'b0);
      gseq = {gseq, m_wcpu ? "C" : (m_wext ? "E" : "-")};
      sseq = {sseq, cpu_stall ? "1" : "0"};
      if (int'(dbg_starve) > peak) peak = int'(dbg_starve);
      @(posedge clk);
      if (m_wcpu || m_wext) begin
         if (e_wen) ref_mem[e_addr[7:0]] = e_wd;
         else begin
            exp_q.push_back(ref_mem[e_addr[7:0]]);
            own_q.push_back(m_wext);
         end
      end
      if (m_wext) m_starve = 0;
      else if (ereq) m_starve = (m_starve == 15) ? 15 : m_starve + 1;
      if (!m_ext_pri && m_starve >= N) m_ext_pri = 1'b1;
      else if (m_ext_pri && m_wext) m_ext_pri = 1'b0;
      @(negedge clk);
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   bit          cp, ep;
   logic        cw, ew;
   logic [31:0] ca, cd, ea, ed;
   int          s_before;
   bit          p_before;

   initial begin
      for (int i = 0; i < 256; i++) begin
         sram[i]    = 32'h1000_0000 + 32'(i);
         ref_mem[i] = 32'h1000_0000 + 32'(i);
      end
      sram[8'h10] = 32'hDEADBEEF; ref_mem[8'h10] = 32'hDEADBEEF;
      model_reset();
      gseq = ""; sseq = ""; peak = 0;

      // reset: requests present, every output must still be 0
      arst_n = 1'b0;
      cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 32'h44; cpu_wdata = 32'h55;
      ext_req = 1'b1; ext_wen = 1'b1; ext_addr = 32'h66; ext_wdata = 32'h77;
      #1;
      chk1("rst_cpu_gnt", cpu_gnt, 1'b0);
      chk1("rst_ext_gnt", ext_gnt, 1'b0);
      chk1("rst_stall", cpu_stall, 1'b0);
      chk1("rst_mem_wen", mem_wen, 1'b0);
      chk1("rst_mem_ren", mem_ren, 1'b0);
      chkw("rst_mem_addr", mem_addr, 32'h0);
      chkw("rst_mem_wdata", mem_wdata, 32'h0);
      chk1("rst_cpu_rvalid", cpu_rvalid, 1'b0);
      chk1("rst_ext_rvalid", ext_rvalid, 1'b0);
      chkw("rst_starve", 32'(dbg_starve), 32'h0);
      chk1("rst_pri", dbg_pri, 1'b0);
      @(negedge clk);
      arst_n = 1'b1;

      // CPU-only read of 0xDEADBEEF at 0x10, return in the following cycle
      cycle(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      idle();

      // both held continuously for 10 cycles
      gseq = ""; sseq = ""; peak = 0;
      for (int i = 0; i < 10; i++)
         cycle(1'b1, 1'b0, 32'(i), 32'h0, 1'b1, 1'b0, 32'h80, 32'h0);
      chks("grant_seq", gseq, "CCCCECCCCE");
      chks("stall_seq", sseq, "0000100001");
      chkw("starve_peak", 32'(peak), 32'd4);
      idle();

      // ext write then CPU read of the same address
      cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h12345678);
      cycle(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      idle();

      // build ext priority with CPU writes, then E@0x4 and C@0x8 on consecutive grants
      for (int i = 0; i < N; i++)
         cycle(1'b1, 1'b1, 32'h30 + 32'(i), 32'hA000_0000 + 32'(i), 1'b1, 1'b0, 32'h4, 32'h0);
      cycle(1'b1, 1'b0, 32'h8, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0);
      cycle(1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      idle();

      // reset between a CPU read grant and the next edge, with starve_cnt nonzero
      cycle(1'b1, 1'b1, 32'h40, 32'h1, 1'b1, 1'b0, 32'h50, 32'h0);
      cycle(1'b1, 1'b1, 32'h41, 32'h2, 1'b1, 1'b0, 32'h50, 32'h0);
      cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 32'h10;
      #1;
      chk1("mid_cpu_gnt", cpu_gnt, 1'b1);
      chkw("mid_starve_pre", 32'(dbg_starve), 32'd2);
      #1 arst_n = 1'b0;
      #1;
      chk1("mid_cpu_gnt_rst", cpu_gnt, 1'b0);
      chk1("mid_ext_gnt_rst", ext_gnt, 1'b0);
      chk1("mid_mem_ren_rst", mem_ren, 1'b0);
      chkw("mid_starve_rst", 32'(dbg_starve), 32'h0);
      @(posedge clk);
      #1;
      chk1("mid_cpu_rvalid", cpu_rvalid, 1'b0);
      @(negedge clk);
      arst_n = 1'b1;
      model_reset();
      cycle(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h50, 32'h0);
      chks("post_rst_winner", gseq.substr(gseq.len() - 1, gseq.len() - 1), "C");
      cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h50, 32'h0);

      // idle: state must hold, nothing on the memory pins
      cycle(1'b1, 1'b1, 32'h60, 32'h9, 1'b1, 1'b0, 32'h61, 32'h0);
      s_before = int'(dbg_starve); p_before = dbg_pri;
      for (int i = 0; i < 5; i++) begin
         cpu_req = 1'b0;
         ext_req = 1'b0;
         #1;
         chk1("idle_mem_wen", mem_wen, 1'b0);
         chk1("idle_mem_ren", mem_ren, 1'b0);
         @(negedge clk);
      end
      chkw("idle_starve_hold", 32'(dbg_starve), 32'(s_before));
      chk1("idle_pri_hold", dbg_pri, p_before);
      // the ext request that was pending is reissued and served
      cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h61, 32'h0);
      idle();

      // randomized traffic, each requester holding until granted
      cp = 1'b0; ep = 1'b0;
      cw = 1'b0; ew = 1'b0; ca = '0; cd = '0; ea = '0; ed = '0;
      for (int i = 0; i < 400; i++) begin
         if (!cp && $urandom_range(0, 3) != 0) begin
            cp = 1'b1; cw = 1'($urandom_range(0, 1));
            ca = 32'($urandom_range(0, 31)); cd = $urandom;
         end
         if (!ep && $urandom_range(0, 2) != 0) begin
            ep = 1'b1; ew = 1'($urandom_range(0, 1));
            ea = 32'($urandom_range(0, 31)); ed = $urandom;
         end
         cycle(cp, cw, ca, cd, ep, ew, ea, ed);
         if (m_wcpu) cp = 1'b0;
         if (m_wext) ep = 1'b0;
      end
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data SRAM between two requesters: the CPU MEM stage and the external load/debug port.
- Sits between the pipeline's MEM-stage signals and the data memory address, write-enable, read-enable and write-data pins.
- Returns read data with the SRAM's one-cycle read latency to the requester that issued the read.
- Drives a stall to the pipeline whenever the CPU loses arbitration. A starvation counter keeps the external port from being locked out indefinitely.

Parameters:
- ADDR_W, 32, address width for both requesters and the memory.
- DATA_W, 32, data word width.
- STARVE_MAX, 4, number of consecutive lost cycles after which the external requester takes priority; legal range 1..15.

Ports:
- clk  in  1  main clock
- arst_n  in  1  asynchronous active-low reset
- cpu_req  in  1  CPU access request, held until granted
- cpu_wen  in  1  1=write, 0=read; qualified by cpu_req
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  CPU access accepted this cycle
- cpu_stall  out  1  cpu_req & ~cpu_gnt; freezes the pipeline
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  DATA_W  CPU read data
- ext_req  in  1  external access request, held until granted
- ext_wen  in  1  1=write, 0=read
- ext_addr  in  ADDR_W  external address
- ext_wdata  in  DATA_W  external write data
- ext_gnt  out  1  external access accepted this cycle
- ext_rvalid  out  1  external read data valid
- ext_rdata  out  DATA_W  external read data
- mem_addr  out  ADDR_W  SRAM address
- mem_wen  out  1  SRAM write enable
- mem_ren  out  1  SRAM read enable
- mem_wdata  out  DATA_W  SRAM write data
- mem_rdata  in  DATA_W  SRAM read data, valid the cycle after mem_ren

Behaviour:
- Clocking: single clock; reset is asynchronous and active-low.
- State registers:
  - pri: PRI_CPU or PRI_EXT.
  - starve_cnt: 4 bits, saturating.
  - rd_owner: NONE, CPU or EXT.
- Reset values: pri=PRI_CPU, starve_cnt=0, rd_owner=NONE. While arst_n=0, all outputs are 0.
- Arbitration is combinational within the cycle.
  - Only one requester active: that requester wins.
  - Both active: pri selects the winner.
  - Neither active: no grant, mem_wen=mem_ren=0, and mem_addr/mem_wdata=0.
- Winner drives mem_addr and mem_wdata. mem_wen = winner's wen; mem_ren = ~winner's wen. Exactly one gnt is high when any request is high.
- Requester rules:
  - A request is consumed on a cycle with req&gnt.
  - A requester that is not granted keeps req, wen, addr and wdata stable.
  - Arbiter behaviour is undefined if these inputs change while ungranted.
- starve_cnt, updated on each clock edge:
  - ext_req & ~ext_gnt: increment, saturating at 15.
  - ext_gnt: clear to 0.
  - Otherwise: hold.
- pri transitions:
  - PRI_CPU -> PRI_EXT when the next starve_cnt value is >= STARVE_MAX.
  - PRI_EXT -> PRI_CPU on the edge where ext_gnt=1.
  - PRI_EXT otherwise holds, even if ext_req drops; a later ext_req wins at once.
- With STARVE_MAX=N and both requesters continuously active, the external port wins exactly one cycle in every N+1.
- Read return:
  - A granted read sets rd_owner to the winner on the next edge.
  - A write or idle cycle sets rd_owner=NONE.
  - cpu_rvalid = (rd_owner==CPU); ext_rvalid = (rd_owner==EXT).
  - x_rdata = mem_rdata when x_rvalid, else 0.
  - Read latency: exactly 1 cycle from grant.
  - Back-to-back reads by alternating owners return in grant order, one per cycle, with no bubble.
- Write-then-read to the same address in consecutive cycles returns the new data, since the SRAM writes on the edge.
- Reset mid-operation: any pending rvalid is dropped, starve_cnt is cleared and pri returns to PRI_CPU. The requester must reissue.
- Size: no FIFO, no buffering beyond rd_owner. Target is about 150 lines of RTL.

Test Plan:
- CPU-only read: cpu_req=1, cpu_wen=0, cpu_addr=0x10, with 0xDEADBEEF stored.
  - Required: cpu_gnt=1 and mem_ren=1 in cycle 0.
  - Required: cpu_rvalid=1 and cpu_rdata=0xDEADBEEF in cycle 1; ext_rvalid=0 throughout.
- Simultaneous requests, STARVE_MAX=4, both held continuously for 10 cycles:
  - Required grant sequence: C,C,C,C,E,C,C,C,C,E.
  - Required: cpu_stall high exactly in cycles 4 and 9; starve_cnt peaks at 4.
- External write 0x12345678 to 0x20, then CPU read of 0x20 in the next cycle:
  - Required: cpu_rdata=0x12345678 with cpu_rvalid one cycle after the CPU grant.
- Interleaved reads, E@0x4 then C@0x8 on consecutive grants (pri forced to PRI_EXT):
  - Required: ext_rvalid in cycle 1 carrying mem[0x4]; cpu_rvalid in cycle 2 carrying mem[0x8].
  - Required: both rvalid flags are never high together.
- Reset mid-read: assert arst_n=0 asynchronously between a CPU read grant and the next edge.
  - Required: cpu_rvalid=0, all gnt=0, starve_cnt=0; after release the first both-request cycle grants the CPU.
- Idle: no requests for 5 cycles.
  - Required: mem_wen=mem_ren=0, both rvalid=0, pri and starve_cnt unchanged.
